// File: rtl/dual_read_register_file.sv
// Configuration register file: one masked write port, two registered read ports,
// write protection, out-of-range detection and a flat export of the low registers.
module dual_read_register_file #(
  parameter int DATA_WIDTH = 8,
  parameter int REGISTER_FILE_DEPTH = 16,
  parameter int NUM_EXPOSED = 4,
  parameter logic [REGISTER_FILE_DEPTH-1:0] WRITE_PROTECT_MASK = '0,
  localparam int ADDRESS_WIDTH = (REGISTER_FILE_DEPTH > 1) ? $clog2(REGISTER_FILE_DEPTH) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              write_enable,
  input  logic [ADDRESS_WIDTH-1:0]          write_address,
  input  logic [DATA_WIDTH-1:0]             write_data,
  input  logic [DATA_WIDTH-1:0]             write_mask,
  input  logic                              read_enable_a,
  input  logic [ADDRESS_WIDTH-1:0]          read_address_a,
  output logic [DATA_WIDTH-1:0]             read_data_a,
  output logic                              read_data_valid_a,
  input  logic                              read_enable_b,
  input  logic [ADDRESS_WIDTH-1:0]          read_address_b,
  output logic [DATA_WIDTH-1:0]             read_data_b,
  output logic                              read_data_valid_b,
  output logic                              write_error,
  output logic [NUM_EXPOSED*DATA_WIDTH-1:0] exposed_registers
);

  // Kept in flops rather than RAM: the export needs every low register in parallel.
  logic [DATA_WIDTH-1:0] regs_reg  [REGISTER_FILE_DEPTH];
  logic [DATA_WIDTH-1:0] regs_next [REGISTER_FILE_DEPTH];

  logic [REGISTER_FILE_DEPTH-1:0] write_hit;
  logic                           write_in_range;
  logic                           write_protected;
  logic                           write_legal;

  logic [DATA_WIDTH-1:0] read_value_a;
  logic [DATA_WIDTH-1:0] read_value_b;

  logic [DATA_WIDTH-1:0] read_data_a_reg;
  logic [DATA_WIDTH-1:0] read_data_b_reg;
  logic                  read_data_valid_a_reg;
  logic                  read_data_valid_b_reg;
  logic                  write_error_reg;

  genvar gi;
  generate
    for (gi = 0; gi < REGISTER_FILE_DEPTH; gi++) begin : g_write_decode
      assign write_hit[gi] = (write_address == ADDRESS_WIDTH'(gi));
    end
    for (gi = 0; gi < NUM_EXPOSED; gi++) begin : g_export
      assign exposed_registers[gi*DATA_WIDTH +: DATA_WIDTH] = regs_reg[gi];
    end
  endgenerate

  // An address with no decode hit lies beyond the last register.
  assign write_in_range  = |write_hit;
  assign write_protected = |(write_hit & WRITE_PROTECT_MASK);
  assign write_legal     = write_enable & write_in_range & ~write_protected;

  always_comb begin
    for (int i = 0; i < REGISTER_FILE_DEPTH; i++) begin
      regs_next[i] = regs_reg[i];
      if (write_legal && write_hit[i]) begin
        regs_next[i] = (regs_reg[i] & ~write_mask) | (write_data & write_mask);
      end
    end
  end

  // Reading from the post-write image gives write-first collision behaviour for free.
  always_comb begin
    read_value_a = '0;
    read_value_b = '0;
    for (int i = 0; i < REGISTER_FILE_DEPTH; i++) begin
      if (read_address_a == ADDRESS_WIDTH'(i)) read_value_a = regs_next[i];
      if (read_address_b == ADDRESS_WIDTH'(i)) read_value_b = regs_next[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REGISTER_FILE_DEPTH; i++) begin
        regs_reg[i] <= '0;
      end
      read_data_a_reg       <= '0;
      read_data_b_reg       <= '0;
      read_data_valid_a_reg <= 1'b0;
      read_data_valid_b_reg <= 1'b0;
      write_error_reg       <= 1'b0;
    end else begin
      for (int i = 0; i < REGISTER_FILE_DEPTH; i++) begin
        regs_reg[i] <= regs_next[i];
      end
      read_data_valid_a_reg <= read_enable_a;
      read_data_valid_b_reg <= read_enable_b;
      if (read_enable_a) read_data_a_reg <= read_value_a;
      if (read_enable_b) read_data_b_reg <= read_value_b;
      write_error_reg <= write_enable & ~write_legal;
    end
  end

  assign read_data_a       = read_data_a_reg;
  assign read_data_b       = read_data_b_reg;
  assign read_data_valid_a = read_data_valid_a_reg;
  assign read_data_valid_b = read_data_valid_b_reg;
  assign write_error       = write_error_reg;

endmodule
